bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `bit_out`, which drives the detector's serial `in` input directly. A one-word holding stage lets a producer keep the line busy with no idle gaps between words. When no data is pending the line sits at IDLE_BIT, so downstream detectors see a quiet line.

## Interface
- WIDTH, 8: word width in bits, ≥2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: value driven on `bit_out` whenever no bit is valid.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- areset_n  input  1  asynchronous active-low reset.
- s_valid  input  1  producer has a word on s_data.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  WIDTH  word to serialize; sampled on the accept edge.
- bit_out  output  1  serial bit, registered.
- bit_valid  output  1  bit_out carries a data bit this cycle.
- word_start  output  1  high during the first bit of each word.
- idle  output  1  shifter and holding stage both empty.

## Operation
- Accept: a word is accepted on a rising edge when `s_valid && s_ready`. `s_ready` = !hold_vld and depends on flops only, with no combinational path from `s_valid`.
- Shifter FSM, state {EMPTY, SHIFT}, with down-counter `cnt` (clog2(WIDTH) bits) and shift register `sh`.
  - EMPTY→SHIFT: on an edge where a word is available, loaded into `sh` with cnt=WIDTH-1. The word comes from the hold stage if hold_vld, otherwise from the bypass path on an accept.
  - SHIFT, cnt>0: shift one bit, cnt−1.
  - SHIFT, cnt==0 (last bit): if a word is available, reload and stay in SHIFT. Otherwise go to EMPTY.
- Hold stage: an accepted word goes to hold only if the shifter cannot take it on that edge, i.e. state SHIFT and cnt>0. hold_vld clears on the edge its word moves into the shifter.
- Precedence on reload: the hold word always goes before a bypass word. A new accept while hold is full is impossible because s_ready=0.
- Outputs while SHIFT: bit_out = current head bit of `sh`, bit_valid=1, word_start=1 iff cnt==WIDTH-1. While EMPTY: bit_out=IDLE_BIT, bit_valid=0, word_start=0.
- idle = (state==EMPTY) && !hold_vld.
- Reset values: state EMPTY, hold_vld=0, cnt=0, sh=0, bit_out=IDLE_BIT, bit_valid=0, word_start=0, s_ready=1, idle=1.
- Reset mid-word discards the partial word and any held word. No bits are replayed after reset.

## Timing
- Latency: an accept at edge k gives the first bit on bit_out in cycle k+1 (after edge k), when the shifter is EMPTY or on its last bit.
- A word occupies exactly WIDTH consecutive cycles of bit_valid=1.
- Back-to-back: if hold is full when the last bit shifts, the next word's first bit follows in the very next cycle, with zero gap.
- Throughput: one word per WIDTH cycles. Hold accepts at most one word ahead. s_ready drops the cycle after hold fills and rises the cycle after hold drains.
- Only the shifter's head bit reaches bit_out, so s_data changes after the accept edge have no effect.

## Structure
- Shared package `serdes_pkg`:
  - `ser_state_t` typedef {EMPTY, SHIFT}.
  - Constant function `cnt_w(WIDTH)` = clog2(WIDTH).
  - IDLE_BIT default constant, shared with the detector benches.
- One sub-module, `ser_hold_reg`: a WIDTH-bit register with valid flag, load/unload strobes and async active-low reset. The shifter, counter and FSM stay in the top.

## Test plan
1. WIDTH=8, MSB_FIRST=1, send 0xA5 once → bit_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles. bit_valid high for exactly those 8 cycles. word_start only on the first. idle returns to 1 after them.
2. s_valid held high with 0x05 then 0xA0 → 16 contiguous valid bits 00000101 10100000, no gap. s_ready low while hold is full. word_start at bit 0 and bit 8.
3. MSB_FIRST=0, send 0x01 → first bit 1, then seven 0s.
4. Assert areset_n low at bit 3 of 0xFF with 0x0F held → bit_out=IDLE_BIT and bit_valid=0 immediately. After release: idle=1, s_ready=1, no residual bits.
5. Producer idle for 20 cycles → bit_out stays IDLE_BIT, bit_valid=0. An accept on the edge where the last bit shifts loads directly with no gap.
6. Cascade into the sequence detector with word 0x50 (01010000) → detector output high exactly 1 cycle, in the cycle after the second 1 bit is presented.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and constants for the bit serializer and the detector benches
// that consume its serial stream.
package serdes_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Line level when no data bit is valid; detector benches use the same value.
  localparam logic IDLE_BIT_DFLT = 1'b0;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding register with valid flag; lets a producer stay one word
// ahead of the shifter.
module ser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic             vld,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments only, and the data
  // register is reset too so a discarded word never lingers after reset.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end else if (unload) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit
// per clock out on bit_out, with a one-word hold stage for gapless streaming.
module bit_serializer
  import serdes_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DFLT
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_start,
  output logic             idle
);

  localparam int            CW        = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);

  ser_state_t       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [WIDTH-1:0] hold_data, load_word;
  logic             hold_vld;
  logic             accept, can_take, load_sh, hold_load, hold_unload;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // s_ready comes from a flop only, so there is no path from s_valid back out.
  assign s_ready     = !hold_vld;
  assign accept      = s_valid && s_ready;
  assign can_take    = (state == EMPTY) || (cnt == '0);
  assign load_sh     = can_take && (hold_vld || accept);
  assign load_word   = hold_vld ? hold_data : s_data;
  assign hold_load   = accept && !can_take;
  assign hold_unload = load_sh && hold_vld;
  assign idle        = (state == EMPTY) && !hold_vld;

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .areset_n (areset_n),
    .load     (hold_load),
    .unload   (hold_unload),
    .d        (s_data),
    .vld      (hold_vld),
    .q        (hold_data)
  );

  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    case (state)
      EMPTY: begin
        if (load_sh) begin
          state_nx = SHIFT;
          cnt_nx   = CNT_FIRST;
          sh_nx    = load_word;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
          sh_nx  = shift1(sh);
        end else if (load_sh) begin
          cnt_nx = CNT_FIRST;
          sh_nx  = load_word;
        end else begin
          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= EMPTY;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh    <= sh_nx;
    end
  end

  // Line outputs are registered from the next-state values so they track the
  // shifter head exactly while staying glitch-free flop outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      bit_out    <= IDLE_BIT;
      bit_valid  <= 1'b0;
      word_start <= 1'b0;
    end else begin
      bit_out    <= (state_nx == SHIFT) ? head(sh_nx) : IDLE_BIT;
      bit_valid  <= (state_nx == SHIFT);
      word_start <= (state_nx == SHIFT) && (cnt_nx == CNT_FIRST);
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: two serializers (MSB-first idle-0, LSB-first idle-1)
// compared each cycle against a bit-queue model of the serial line.
module tb_bit_serializer;
  import serdes_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic first;
  } mbit_t;
  typedef mbit_t mq_t[$];

  logic         clk = 1'b0;
  logic         areset_n;
  logic         s_valid0, s_valid1;
  logic [W-1:0] s_data0, s_data1;
  logic         s_ready0, bit_out0, bit_valid0, word_start0, idle0;
  logic         s_ready1, bit_out1, bit_valid1, word_start1, idle1;

  int  vectors     = 0;
  int  miscompares = 0;
  mq_t mq0, mq1;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .areset_n(areset_n), .s_valid(s_valid0), .s_ready(s_ready0),
    .s_data(s_data0), .bit_out(bit_out0), .bit_valid(bit_valid0),
    .word_start(word_start0), .idle(idle0)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .areset_n(areset_n), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .bit_out(bit_out1), .bit_valid(bit_valid1),
    .word_start(word_start1), .idle(idle1)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Line model: queue of bits still to appear; head is on the line now.
  // A word waits fully behind the current one (hold full) when size > W.
  function automatic mq_t step_q(input mq_t q, input logic v,
                                 input logic [W-1:0] d, input bit msb);
    bit    acc;
    mbit_t e;
    acc = v && (q.size() <= W);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      for (int k = 0; k < W; k++) begin
        e.b     = d[msb ? (W - 1 - k) : k];
        e.first = (k == 0);
        q.push_back(e);
      end
    end
    return q;
  endfunction

  task automatic check_one(input string ph, input string nm, input mq_t q,
                           input logic idle_lvl, input logic [4:0] obs);
    logic [4:0] exp;
    if (q.size() > 0) exp = {q[0].b, 1'b1, q[0].first, 1'b0, 1'b0};
    else              exp = {idle_lvl, 1'b0, 1'b0, 1'b0, 1'b1};
    exp[1] = (q.size() <= W);
    check($sformatf("%s/%s bit_out", ph, nm),    obs[4], exp[4]);
    check($sformatf("%s/%s bit_valid", ph, nm),  obs[3], exp[3]);
    check($sformatf("%s/%s word_start", ph, nm), obs[2], exp[2]);
    check($sformatf("%s/%s s_ready", ph, nm),    obs[1], exp[1]);
    check($sformatf("%s/%s idle", ph, nm),       obs[0], exp[0]);
  endtask

  task automatic check_all(input string ph);
    check_one(ph, "msb", mq0, 1'b0,
              {bit_out0, bit_valid0, word_start0, s_ready0, idle0});
    check_one(ph, "lsb", mq1, 1'b1,
              {bit_out1, bit_valid1, word_start1, s_ready1, idle1});
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    if (!areset_n) begin
      mq0.delete();
      mq1.delete();
    end else begin
      mq0 = step_q(mq0, s_valid0, s_data0, 1'b1);
      mq1 = step_q(mq1, s_valid1, s_data1, 1'b0);
    end
    @(negedge clk);
    check_all(ph);
  endtask

  // Holds s_valid until the model says the word was taken, then scrambles
  // s_data so a late sample of it would show up as wrong bits.
  task automatic send(input string ph, input int inst, input logic [W-1:0] w);
    bit done = 1'b0;
    if (inst == 0) begin s_valid0 = 1'b1; s_data0 = w; end
    else           begin s_valid1 = 1'b1; s_data1 = w; end
    for (int n = 0; n < 4 * W && !done; n++) begin
      done = ((inst == 0) ? mq0.size() : mq1.size()) <= W;
      cycle(ph);
    end
    check($sformatf("%s accept within budget", ph), done, 1'b1);
    if (inst == 0) begin s_valid0 = 1'b0; s_data0 = W'($urandom); end
    else           begin s_valid1 = 1'b0; s_data1 = W'($urandom); end
  endtask

  initial begin
    bit s[8];
    int hits, pos;

    areset_n = 1'b0;
    s_valid0 = 1'b0; s_valid1 = 1'b0;
    s_data0  = '0;   s_data1  = '0;
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    areset_n = 1'b1;
    cycle("post_reset");

    // Single word, MSB first.
    send("a5", 0, 8'hA5);
    repeat (10) cycle("a5");

    // Back-to-back words through the hold stage.
    send("b2b", 0, 8'h05);
    send("b2b", 0, 8'hA0);
    repeat (18) cycle("b2b");

    // LSB-first single word.
    send("lsb01", 1, 8'h01);
    repeat (10) cycle("lsb01");

    // Reset at bit 3 of 0xFF with 0x0F held.
    send("rst", 0, 8'hFF);
    send("rst", 0, 8'h0F);
    cycle("rst");
    cycle("rst");
    areset_n = 1'b0;
    #1;
    mq0.delete();
    mq1.delete();
    check_all("rst_async");
    cycle("rst_low");
    areset_n = 1'b1;
    repeat (12) cycle("rst_after");

    // Quiet line, then an accept exactly on the last-bit edge.
    repeat (20) cycle("quiet");
    send("lastedge", 0, 8'h3C);
    for (int n = 0; n < 2 * W && mq0.size() != 1; n++) cycle("lastedge");
    send("lastedge", 0, 8'hC3);
    repeat (10) cycle("lastedge");

    // 0x50 into a 0101 detector: exactly one hit, on the second 1 bit.
    send("det", 0, 8'h50);
    for (int k = 0; k < 8; k++) begin
      s[k] = bit_out0;
      cycle("det");
    end
    hits = 0;
    pos  = -1;
    for (int k = 3; k < 8; k++) begin
      if (!s[k-3] && s[k-2] && !s[k-1] && s[k]) begin
        hits++;
        pos = k;
      end
    end
    check("det single hit at bit 3", (hits == 1) && (pos == 3), 1'b1);
    repeat (4) cycle("det");

    // Random words, gaps and instances.
    for (int r = 0; r < 40; r++) begin
      send("rand", int'($urandom_range(0, 1)), W'($urandom));
      repeat ($urandom_range(0, 2)) cycle("rand");
    end
    repeat (24) cycle("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
